ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the ID/EX pipeline bundle and produces the registered EX/MEM bundle.
//  Performs ALU ops and load/store address generation for the 4-thread 16-bit core.
//  Shifts run bit-serially to save area; stall_o holds the ID/EX bundle while a shift runs.
// PARAMETERS
//  PROC_DATA_WIDTH        16  datapath width; shift amount is operand B[3:0]
//  PROC_REGFILE_LOG2_DEEP 5   destination register index width
//  INSTMEM_LOG2_DEEP      8   PC baggage width
// PORTS
//  CLK                 in   1   clock, rising edge
//  RST_N               in   1   reset, asynchronous, active-low
//  valid_in            in   1   ID/EX bundle holds a real instruction
//  WRegEn_in           in   1   register write enable
//  WMemEn_in           in   1   store
//  alu_src_in          in   1   1: operand B = sign_ext_in; 0: B = R2out_in
//  mem_to_reg_in       in   1   load
//  R1out_in            in   DW  operand A
//  R2out_in            in   DW  operand B (reg) / store data
//  sign_ext_in         in   DW  immediate
//  WReg1_in            in   RW  destination register
//  func3_in            in   3   ALU op
//  func7_in            in   1   sub / sra select
//  thread_id_in        in   2   issuing thread
//  pc_carry_baggage_i  in   IW  PC of instruction
//  stall_o             out  1   EX busy; upstream must hold the bundle
//  valid_out           out  1   EX/MEM bundle valid this cycle
//  WRegEn_out          out  1   gated by valid_out
//  WMemEn_out          out  1   gated by valid_out
//  mem_to_reg_out      out  1   load flag
//  alu_result_out      out  DW  ALU result or memory address
//  store_data_out      out  DW  R2out_in of the instruction
//  WReg1_out           out  RW  destination register
//  thread_id_out       out  2   thread id
//  pc_carry_baggage_o  out  IW  PC baggage
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, stall_o=0. A reset mid-SHIFT aborts the shift; no result is emitted.
//  Operand B = alu_src_in ? sign_ext_in : R2out_in.
//  WMemEn_in|mem_to_reg_in: result = A+B mod 2^16; func fields are ignored.
//  func3: 000 add (sub if func7=1 and alu_src=0); 001 sll; 010 slt signed; 011 sltu;
//         100 xor; 101 srl (func7=0) / sra (func7=1); 110 or; 111 and. slt/sltu return 16'd0 or 16'd1.
//  FSM IDLE: bundle is accepted on an edge with valid_in=1.
//   Non-shift, or shift with amount 0: one-cycle latency. Outputs are valid after the accept edge with valid_out=1.
//   Shift with amount n>=1: capture A, op, and all baggage; cnt<=n; go to SHIFT; valid_out<=0.
//  FSM SHIFT: shift 1 bit per edge (sra fills with sign); cnt decrements each edge.
//   On the edge where cnt==1, load the result plus baggage into the outputs, set valid_out<=1, return to IDLE.
//   Result is visible n edges after the accept edge.
//  stall_o = (state==SHIFT), from a register only, no combinational input path. It is high for exactly n cycles.
//   Bundle inputs and valid_in are ignored in SHIFT.
//  valid_in=0 in IDLE: bubble. valid_out, WRegEn_out and WMemEn_out go to 0; other outputs hold.
//  valid_out is high for exactly one cycle per accepted instruction. The next instruction is accepted on the completion edge+1.
//  Baggage (WReg1, thread_id, pc, mem_to_reg, store data) always stays aligned with its own result.
// TESTING
//  add: A=16'h7FFF, R2=1, alu_src=0, f3=000 -> 1 cycle later valid_out=1, result=16'h8000, stall_o never high.
//  sub/slt: A=3, B=5, f7=1 -> result 16'hFFFE; f3=010 A=16'hFFFF B=1 -> 1; f3=011 -> 0.
//  sra: A=16'h8000, imm=4, alu_src=1, f3=101, f7=1 -> stall_o high 4 cycles, then result 16'hF800; next bundle accepted after.
//  load addr: mem_to_reg=1, A=16'h0010, imm=16'hFFFC -> result 16'h000C, WRegEn_out=1, thread_id/pc/WReg1 match.
//  bubbles and gating: valid_in=0 -> valid_out=0, WRegEn_out=WMemEn_out=0; sll amount 0 -> no stall.
//  reset: assert RST_N=0 mid-shift (cnt=2) -> outputs immediately 0, stall_o=0, no valid_out after release.

Source files
------------

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the 4-thread 16-bit core. Consumes the ID/EX bundle and
// produces the registered EX/MEM bundle: ALU result (or load/store address)
// together with the instruction's baggage (dest reg, thread, PC, flags).
// Shifts by a non-zero amount run one bit per cycle; while one is in flight
// stall_o tells upstream to hold its bundle.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   valid_in              ID/EX bundle carries a real instruction
//   WRegEn_in, WMemEn_in  register write / store enables
//   alu_src_in            1: operand B = sign_ext_in, 0: operand B = R2out_in
//   mem_to_reg_in         load
//   R1out_in, R2out_in    operand A, operand B (reg) / store data
//   sign_ext_in           immediate
//   WReg1_in              destination register
//   func3_in, func7_in    ALU op select, sub/sra select
//   thread_id_in          issuing thread
//   pc_carry_baggage_i    PC of the instruction
//   stall_o               EX busy with a serial shift
//   valid_out .. pc_carry_baggage_o  registered EX/MEM bundle
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int INSTMEM_LOG2_DEEP      = 8
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              valid_in,
  input  logic                              WRegEn_in,
  input  logic                              WMemEn_in,
  input  logic                              alu_src_in,
  input  logic                              mem_to_reg_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R1out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R2out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        sign_ext_in,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_in,
  input  logic [2:0]                        func3_in,
  input  logic                              func7_in,
  input  logic [1:0]                        thread_id_in,
  input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_i,
  output logic                              stall_o,
  output logic                              valid_out,
  output logic                              WRegEn_out,
  output logic                              WMemEn_out,
  output logic                              mem_to_reg_out,
  output logic [PROC_DATA_WIDTH-1:0]        alu_result_out,
  output logic [PROC_DATA_WIDTH-1:0]        store_data_out,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_out,
  output logic [1:0]                        thread_id_out,
  output logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_o
);

  localparam int DW = PROC_DATA_WIDTH;
  localparam int RW = PROC_REGFILE_LOG2_DEEP;
  localparam int IW = INSTMEM_LOG2_DEEP;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   shReg_q, shReg_d;
  logic            shLeft_q, shLeft_d;
  logic            shArith_q, shArith_d;

  // Baggage parked here while a serial shift runs
  logic            bagWRegEn_q, bagWRegEn_d;
  logic            bagWMemEn_q, bagWMemEn_d;
  logic            bagMemToReg_q, bagMemToReg_d;
  logic [DW-1:0]   bagStore_q, bagStore_d;
  logic [RW-1:0]   bagWReg_q, bagWReg_d;
  logic [1:0]      bagTid_q, bagTid_d;
  logic [IW-1:0]   bagPc_q, bagPc_d;

  // EX/MEM output registers
  logic            valid_q, valid_d;
  logic            wRegEn_q, wRegEn_d;
  logic            wMemEn_q, wMemEn_d;
  logic            memToReg_q, memToReg_d;
  logic [DW-1:0]   result_q, result_d;
  logic [DW-1:0]   store_q, store_d;
  logic [RW-1:0]   wReg_q, wReg_d;
  logic [1:0]      tid_q, tid_d;
  logic [IW-1:0]   pc_q, pc_d;

  logic [DW-1:0]   opB;
  logic            isAddr;
  logic            isShift;
  logic [DW-1:0]   aluRes;
  logic [DW-1:0]   shNext;

  // Operand select and single-cycle ALU. Shift ops only reach this path with
  // a zero amount, so they simply pass operand A through.
  always_comb begin
    opB     = alu_src_in ? sign_ext_in : R2out_in;
    isAddr  = WMemEn_in | mem_to_reg_in;
    isShift = !isAddr && ((func3_in == 3'b001) || (func3_in == 3'b101));
    aluRes  = '0;
    if (isAddr) begin
      aluRes = R1out_in + opB;
    end else begin
      case (func3_in)
        3'b000: aluRes = (func7_in && !alu_src_in) ? (R1out_in - opB) : (R1out_in + opB);
        3'b010: aluRes = {{(DW-1){1'b0}}, ($signed(R1out_in) < $signed(opB))};
        3'b011: aluRes = {{(DW-1){1'b0}}, (R1out_in < opB)};
        3'b100: aluRes = R1out_in ^ opB;
        3'b110: aluRes = R1out_in | opB;
        3'b111: aluRes = R1out_in & opB;
        default: aluRes = R1out_in;
      endcase
    end
  end

  // One step of the serial shifter; arithmetic right shifts replicate the sign bit
  always_comb begin
    if (shLeft_q) begin
      shNext = {shReg_q[DW-2:0], 1'b0};
    end else begin
      shNext = {shArith_q & shReg_q[DW-1], shReg_q[DW-1:1]};
    end
  end

  // Next-state logic. valid and the write enables default low so bubbles and
  // in-flight shifts never present a write downstream; data outputs hold.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shReg_d       = shReg_q;
    shLeft_d      = shLeft_q;
    shArith_d     = shArith_q;
    bagWRegEn_d   = bagWRegEn_q;
    bagWMemEn_d   = bagWMemEn_q;
    bagMemToReg_d = bagMemToReg_q;
    bagStore_d    = bagStore_q;
    bagWReg_d     = bagWReg_q;
    bagTid_d      = bagTid_q;
    bagPc_d       = bagPc_q;
    valid_d       = 1'b0;
    wRegEn_d      = 1'b0;
    wMemEn_d      = 1'b0;
    memToReg_d    = memToReg_q;
    result_d      = result_q;
    store_d       = store_q;
    wReg_d        = wReg_q;
    tid_d         = tid_q;
    pc_d          = pc_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (isShift && (opB[3:0] != 4'd0)) begin
            state_d       = SHIFT;
            cnt_d         = opB[3:0];
            shReg_d       = R1out_in;
            shLeft_d      = (func3_in == 3'b001);
            shArith_d     = func7_in;
            bagWRegEn_d   = WRegEn_in;
            bagWMemEn_d   = WMemEn_in;
            bagMemToReg_d = mem_to_reg_in;
            bagStore_d    = R2out_in;
            bagWReg_d     = WReg1_in;
            bagTid_d      = thread_id_in;
            bagPc_d       = pc_carry_baggage_i;
          end else begin
            valid_d    = 1'b1;
            wRegEn_d   = WRegEn_in;
            wMemEn_d   = WMemEn_in;
            memToReg_d = mem_to_reg_in;
            result_d   = aluRes;
            store_d    = R2out_in;
            wReg_d     = WReg1_in;
            tid_d      = thread_id_in;
            pc_d       = pc_carry_baggage_i;
          end
        end
      end
      SHIFT: begin
        shReg_d = shNext;
        cnt_d   = cnt_q - 4'd1;
        // Last step: publish the fully shifted value with its own baggage
        if (cnt_q == 4'd1) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          wRegEn_d   = bagWRegEn_q;
          wMemEn_d   = bagWMemEn_q;
          memToReg_d = bagMemToReg_q;
          result_d   = shNext;
          store_d    = bagStore_q;
          wReg_d     = bagWReg_q;
          tid_d      = bagTid_q;
          pc_d       = bagPc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any shift in progress
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shReg_q       <= '0;
      shLeft_q      <= 1'b0;
      shArith_q     <= 1'b0;
      bagWRegEn_q   <= 1'b0;
      bagWMemEn_q   <= 1'b0;
      bagMemToReg_q <= 1'b0;
      bagStore_q    <= '0;
      bagWReg_q     <= '0;
      bagTid_q      <= '0;
      bagPc_q       <= '0;
      valid_q       <= 1'b0;
      wRegEn_q      <= 1'b0;
      wMemEn_q      <= 1'b0;
      memToReg_q    <= 1'b0;
      result_q      <= '0;
      store_q       <= '0;
      wReg_q        <= '0;
      tid_q         <= '0;
      pc_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shReg_q       <= shReg_d;
      shLeft_q      <= shLeft_d;
      shArith_q     <= shArith_d;
      bagWRegEn_q   <= bagWRegEn_d;
      bagWMemEn_q   <= bagWMemEn_d;
      bagMemToReg_q <= bagMemToReg_d;
      bagStore_q    <= bagStore_d;
      bagWReg_q     <= bagWReg_d;
      bagTid_q      <= bagTid_d;
      bagPc_q       <= bagPc_d;
      valid_q       <= valid_d;
      wRegEn_q      <= wRegEn_d;
      wMemEn_q      <= wMemEn_d;
      memToReg_q    <= memToReg_d;
      result_q      <= result_d;
      store_q       <= store_d;
      wReg_q        <= wReg_d;
      tid_q         <= tid_d;
      pc_q          <= pc_d;
    end
  end

  // stall_o decodes the state register only, so it has no path from inputs
  assign stall_o            = (state_q == SHIFT);
  assign valid_out          = valid_q;
  assign WRegEn_out         = wRegEn_q;
  assign WMemEn_out         = wMemEn_q;
  assign mem_to_reg_out     = memToReg_q;
  assign alu_result_out     = result_q;
  assign store_data_out     = store_q;
  assign WReg1_out          = wReg_q;
  assign thread_id_out      = tid_q;
  assign pc_carry_baggage_o = pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage: a table of hand-computed vectors, a set
// of hand-written multi-cycle sequences (back-to-back after a shift, reset
// during a shift) and randomized instructions checked against an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        CLK;
  logic        RST_N;
  logic        valid_in;
  logic        WRegEn_in;
  logic        WMemEn_in;
  logic        alu_src_in;
  logic        mem_to_reg_in;
  logic [15:0] R1out_in;
  logic [15:0] R2out_in;
  logic [15:0] sign_ext_in;
  logic [4:0]  WReg1_in;
  logic [2:0]  func3_in;
  logic        func7_in;
  logic [1:0]  thread_id_in;
  logic [7:0]  pc_carry_baggage_i;
  logic        stall_o;
  logic        valid_out;
  logic        WRegEn_out;
  logic        WMemEn_out;
  logic        mem_to_reg_out;
  logic [15:0] alu_result_out;
  logic [15:0] store_data_out;
  logic [4:0]  WReg1_out;
  logic [1:0]  thread_id_out;
  logic [7:0]  pc_carry_baggage_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        aluSrc;
    logic        wRegEn;
    logic        wMemEn;
    logic        memToReg;
    logic [15:0] a;
    logic [15:0] r2;
    logic [15:0] imm;
    logic [4:0]  wReg;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  tid;
    logic [7:0]  pc;
    logic [15:0] expResult;
    int          expLat;
  } vec_t;

  vec_t table_v[15];

  ex_stage dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .valid_in           (valid_in),
    .WRegEn_in          (WRegEn_in),
    .WMemEn_in          (WMemEn_in),
    .alu_src_in         (alu_src_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .R1out_in           (R1out_in),
    .R2out_in           (R2out_in),
    .sign_ext_in        (sign_ext_in),
    .WReg1_in           (WReg1_in),
    .func3_in           (func3_in),
    .func7_in           (func7_in),
    .thread_id_in       (thread_id_in),
    .pc_carry_baggage_i (pc_carry_baggage_i),
    .stall_o            (stall_o),
    .valid_out          (valid_out),
    .WRegEn_out         (WRegEn_out),
    .WMemEn_out         (WMemEn_out),
    .mem_to_reg_out     (mem_to_reg_out),
    .alu_result_out     (alu_result_out),
    .store_data_out     (store_data_out),
    .WReg1_out          (WReg1_out),
    .thread_id_out      (thread_id_out),
    .pc_carry_baggage_o (pc_carry_baggage_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case something stalls the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input logic aluSrc, input logic wRegEn, input logic wMemEn,
                                 input logic memToReg, input logic [15:0] a, input logic [15:0] r2,
                                 input logic [15:0] imm, input logic [4:0] wReg, input logic [2:0] f3,
                                 input logic f7, input logic [1:0] tid, input logic [7:0] pc,
                                 input logic [15:0] expResult, input int expLat);
    vec_t v;
    v.aluSrc = aluSrc; v.wRegEn = wRegEn; v.wMemEn = wMemEn; v.memToReg = memToReg;
    v.a = a; v.r2 = r2; v.imm = imm; v.wReg = wReg; v.f3 = f3; v.f7 = f7;
    v.tid = tid; v.pc = pc; v.expResult = expResult; v.expLat = expLat;
    return v;
  endfunction

  // Reference model: what the instruction computes, straight from the op table
  function automatic logic [15:0] modelResult(input vec_t v);
    logic [15:0]        b;
    logic signed [15:0] sa;
    logic [15:0]        r;
    b  = v.aluSrc ? v.imm : v.r2;
    sa = v.a;
    if (v.wMemEn || v.memToReg) return v.a + b;
    case (v.f3)
      3'd0: r = (v.f7 && !v.aluSrc) ? v.a - b : v.a + b;
      3'd1: r = v.a << b[3:0];
      3'd2: r = ($signed(v.a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd3: r = (v.a < b) ? 16'd1 : 16'd0;
      3'd4: r = v.a ^ b;
      3'd5: r = v.f7 ? 16'(sa >>> b[3:0]) : (v.a >> b[3:0]);
      3'd6: r = v.a | b;
      default: r = v.a & b;
    endcase
    return r;
  endfunction

  // Number of cycles the stage stays busy: the shift amount for shift ops
  function automatic int modelLat(input vec_t v);
    logic [15:0] b;
    b = v.aluSrc ? v.imm : v.r2;
    if (v.wMemEn || v.memToReg) return 0;
    if (v.f3 == 3'd1 || v.f3 == 3'd5) return int'(b[3:0]);
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid_in           = 1'b1;
    alu_src_in         = v.aluSrc;
    WRegEn_in          = v.wRegEn;
    WMemEn_in          = v.wMemEn;
    mem_to_reg_in      = v.memToReg;
    R1out_in           = v.a;
    R2out_in           = v.r2;
    sign_ext_in        = v.imm;
    WReg1_in           = v.wReg;
    func3_in           = v.f3;
    func7_in           = v.f7;
    thread_id_in       = v.tid;
    pc_carry_baggage_i = v.pc;
  endtask

  task automatic checkBundle(input vec_t v, input string tag);
    checkOutput({tag, ".stall"},    32'(stall_o), 32'd0);
    checkOutput({tag, ".valid"},    32'(valid_out), 32'd1);
    checkOutput({tag, ".result"},   32'(alu_result_out), 32'(v.expResult));
    checkOutput({tag, ".wregen"},   32'(WRegEn_out), 32'(v.wRegEn));
    checkOutput({tag, ".wmemen"},   32'(WMemEn_out), 32'(v.wMemEn));
    checkOutput({tag, ".memtoreg"}, 32'(mem_to_reg_out), 32'(v.memToReg));
    checkOutput({tag, ".store"},    32'(store_data_out), 32'(v.r2));
    checkOutput({tag, ".wreg"},     32'(WReg1_out), 32'(v.wReg));
    checkOutput({tag, ".tid"},      32'(thread_id_out), 32'(v.tid));
    checkOutput({tag, ".pc"},       32'(pc_carry_baggage_o), 32'(v.pc));
  endtask

  // Issue one instruction; during a shift, junk is driven (valid_in=1) to
  // confirm the stage ignores its inputs while busy
  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge CLK); #1;
    for (int k = 0; k < v.expLat; k++) begin
      checkOutput({tag, ".stallBusy"}, 32'(stall_o), 32'd1);
      checkOutput({tag, ".validBusy"}, 32'(valid_out), 32'd0);
      valid_in     = 1'b1;
      R1out_in     = 16'($urandom);
      R2out_in     = 16'($urandom);
      sign_ext_in  = 16'($urandom);
      func3_in     = 3'($urandom);
      WReg1_in     = 5'($urandom);
      thread_id_in = 2'($urandom);
      @(posedge CLK); #1;
    end
    checkBundle(v, tag);
  endtask

  task automatic doBubble(input logic [15:0] holdRes, input string tag);
    valid_in  = 1'b0;
    WRegEn_in = 1'b1;
    WMemEn_in = 1'b1;
    R1out_in  = 16'($urandom);
    @(posedge CLK); #1;
    checkOutput({tag, ".bubValid"},  32'(valid_out), 32'd0);
    checkOutput({tag, ".bubWRegEn"}, 32'(WRegEn_out), 32'd0);
    checkOutput({tag, ".bubWMemEn"}, 32'(WMemEn_out), 32'd0);
    checkOutput({tag, ".bubHold"},   32'(alu_result_out), 32'(holdRes));
    checkOutput({tag, ".bubStall"},  32'(stall_o), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stall"},  32'(stall_o), 32'd0);
    checkOutput({tag, ".valid"},  32'(valid_out), 32'd0);
    checkOutput({tag, ".wregen"}, 32'(WRegEn_out), 32'd0);
    checkOutput({tag, ".wmemen"}, 32'(WMemEn_out), 32'd0);
    checkOutput({tag, ".m2r"},    32'(mem_to_reg_out), 32'd0);
    checkOutput({tag, ".result"}, 32'(alu_result_out), 32'd0);
    checkOutput({tag, ".store"},  32'(store_data_out), 32'd0);
    checkOutput({tag, ".wreg"},   32'(WReg1_out), 32'd0);
    checkOutput({tag, ".tid"},    32'(thread_id_out), 32'd0);
    checkOutput({tag, ".pc"},     32'(pc_carry_baggage_o), 32'd0);
  endtask

  initial begin
    vec_t        rv;
    logic [15:0] lastRes;

    //                  src wr wm m2r  A         R2        imm       wreg  f3  f7 tid pc       result    lat
    table_v[0]  = mkVec(0, 1, 0, 0, 16'h7FFF, 16'h0001, 16'h0000, 5'd3,  3'd0, 0, 1, 8'h10, 16'h8000, 0);
    table_v[1]  = mkVec(0, 1, 0, 0, 16'h0003, 16'h0005, 16'h0000, 5'd4,  3'd0, 1, 2, 8'h11, 16'hFFFE, 0);
    table_v[2]  = mkVec(0, 1, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 5'd5,  3'd2, 0, 3, 8'h12, 16'h0001, 0);
    table_v[3]  = mkVec(0, 1, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 5'd6,  3'd3, 0, 0, 8'h13, 16'h0000, 0);
    table_v[4]  = mkVec(1, 1, 0, 0, 16'h8000, 16'h1111, 16'h0004, 5'd7,  3'd5, 1, 1, 8'h14, 16'hF800, 4);
    table_v[5]  = mkVec(1, 1, 0, 1, 16'h0010, 16'h2222, 16'hFFFC, 5'd8,  3'd1, 1, 2, 8'h15, 16'h000C, 0);
    table_v[6]  = mkVec(0, 1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 5'd9,  3'd1, 0, 3, 8'h16, 16'h1234, 0);
    table_v[7]  = mkVec(0, 1, 0, 0, 16'h8000, 16'h000F, 16'h0000, 5'd10, 3'd5, 0, 0, 8'h17, 16'h0001, 15);
    table_v[8]  = mkVec(1, 0, 1, 0, 16'h0100, 16'hBEEF, 16'h0004, 5'd11, 3'd0, 1, 1, 8'h18, 16'h0104, 0);
    table_v[9]  = mkVec(0, 1, 0, 0, 16'hF0F0, 16'h0FF0, 16'h0000, 5'd12, 3'd4, 0, 2, 8'h19, 16'hFF00, 0);
    table_v[10] = mkVec(0, 1, 0, 0, 16'hF000, 16'h000F, 16'h0000, 5'd13, 3'd6, 0, 3, 8'h1A, 16'hF00F, 0);
    table_v[11] = mkVec(0, 1, 0, 0, 16'hF0F0, 16'h0FF0, 16'h0000, 5'd14, 3'd7, 0, 0, 8'h1B, 16'h00F0, 0);
    table_v[12] = mkVec(1, 1, 0, 0, 16'h0001, 16'h3333, 16'h000F, 5'd15, 3'd1, 0, 1, 8'h1C, 16'h8000, 15);
    table_v[13] = mkVec(1, 1, 0, 0, 16'h0003, 16'h4444, 16'h0005, 5'd16, 3'd0, 1, 2, 8'h1D, 16'h0008, 0);
    table_v[14] = mkVec(0, 1, 0, 0, 16'h7000, 16'h0003, 16'h0000, 5'd17, 3'd5, 1, 3, 8'h1E, 16'h0E00, 3);

    RST_N = 1'b0; valid_in = 1'b0; WRegEn_in = 1'b0; WMemEn_in = 1'b0; alu_src_in = 1'b0;
    mem_to_reg_in = 1'b0; R1out_in = '0; R2out_in = '0; sign_ext_in = '0; WReg1_in = '0;
    func3_in = '0; func7_in = 1'b0; thread_id_in = '0; pc_carry_baggage_i = '0;

    repeat (3) @(posedge CLK);
    #1;
    checkAllZero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table, each vector followed by a bubble
    foreach (table_v[i]) begin
      runVec(table_v[i], $sformatf("vec%0d", i));
      doBubble(table_v[i].expResult, $sformatf("vec%0d", i));
    end

    // A shift followed immediately by another instruction
    runVec(table_v[4], "b2b.sra");
    runVec(table_v[9], "b2b.xor");
    runVec(table_v[14], "b2b.sra3");
    runVec(table_v[12], "b2b.sll15");
    doBubble(table_v[12].expResult, "b2b");

    // Reset while the shift counter is at 2: nothing must emerge afterwards
    applyStimulus(table_v[4]);
    @(posedge CLK); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rstMid.stallBefore", 32'(stall_o), 32'd1);
    RST_N = 1'b0;
    #1;
    checkAllZero("rstMid");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      checkOutput("rstMid.noValid", 32'(valid_out), 32'd0);
      checkOutput("rstMid.noStall", 32'(stall_o), 32'd0);
    end
    runVec(table_v[0], "rstMid.recover");

    // Randomized instructions against the reference model
    lastRes = table_v[0].expResult;
    for (int n = 0; n < 150; n++) begin
      rv.aluSrc   = 1'($urandom);
      rv.wRegEn   = 1'($urandom);
      rv.wMemEn   = ($urandom_range(7) == 0);
      rv.memToReg = !rv.wMemEn && ($urandom_range(7) == 0);
      rv.a        = 16'($urandom);
      rv.r2       = 16'($urandom);
      rv.imm      = 16'($urandom);
      rv.wReg     = 5'($urandom);
      rv.f3       = 3'($urandom);
      rv.f7       = 1'($urandom);
      rv.tid      = 2'($urandom);
      rv.pc       = 8'($urandom);
      rv.expResult = modelResult(rv);
      rv.expLat    = modelLat(rv);
      runVec(rv, $sformatf("rnd%0d", n));
      lastRes = rv.expResult;
      if ($urandom_range(3) == 0) doBubble(lastRes, $sformatf("rnd%0d", n));
    end

    valid_in = 1'b0;
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
